// File: rtl/mem_req_pkg.sv
// rtl/mem_req_pkg.sv - shared FSM states and entry-width helper for the memory request sequencer
package mem_req_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // One queued request is {we, addr, wdata}.
    function automatic int entry_w(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - synchronous request FIFO with full/empty flags
module mem_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [W-1:0] store [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr[PW-1:0]] <= push_data;
    end

    assign head  = store[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/mem_req_sequencer.sv
// rtl/mem_req_sequencer.sv - queues host requests, issues them to the memory strobe port, returns ordered responses
module mem_req_sequencer
    import mem_req_pkg::*;
#(
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_ready
);
    localparam int EW = entry_w(AW, DW);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state;
    state_t        next;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          op_we;
    logic          init_done;
    logic [CW-1:0] cnt;

    // init_done keeps req_ready low until the first clock after reset release.
    assign req_ready = init_done && !full;

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid && req_ready),
        .push_data ({req_we, req_addr, req_wdata}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next      = state;
        pop       = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop  = 1'b1;
                    next = ISSUE;
                end
            end
            ISSUE: begin
                mem_write = op_we;
                mem_read  = !op_we;
                next      = WAIT;
            end
            WAIT: begin
                if (mem_ready || cnt == CNT_MAX) next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_done <= 1'b0;
            op_we     <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            cnt       <= '0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (pop) begin
                op_we    <= head[EW-1];
                mem_addr <= head[DW +: AW];
                mem_din  <= head[DW-1:0];
            end
            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + CNT_ONE;
            // Timeout wins only when ready is absent; read data is zeroed for writes and errors.
            if (state == WAIT && (mem_ready || cnt == CNT_MAX)) begin
                rsp_we    <= op_we;
                rsp_err   <= !mem_ready;
                rsp_rdata <= (mem_ready && !op_we) ? mem_dout : '0;
            end
        end
    end

endmodule
